// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-serial program memory loader with core hold and combinational line read
module prog_loader #(
    parameter int DEPTH  = 16,
    parameter int LINE_W = 46
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic                     in_valid,
    input  logic [7:0]               in_byte,
    output logic                     in_ready,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic [LINE_W-1:0]        line,
    output logic                     core_hold,
    output logic                     load_done,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LINE_W-1:0] mem [DEPTH];
    logic [CW-1:0]     n_lines;
    logic [CW-1:0]     wr_ptr;
    logic [2:0]        byte_cnt;
    logic [LINE_W-1:0] asm_q;
    logic              accept;
    logic              hdr_ok;
    logic              top_ok;
    logic              last_line;

    assign in_ready  = (state == S_HDR) || (state == S_DATA);
    assign accept    = in_valid && in_ready;
    assign core_hold = (state != S_IDLE);
    assign load_done = (state == S_DONE);
    assign line      = core_hold ? '0 : mem[addr];

    assign hdr_ok    = (in_byte != 8'd0) && (32'(in_byte) <= DEPTH);
    // Only the line bits are kept; the two guard bits of the first byte are
    // still in the register when the sixth byte arrives, so check them there.
    assign top_ok    = (asm_q[LINE_W-7 -: 2] == 2'b00);
    assign last_line = ((wr_ptr + CW'(1)) == n_lines);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load_en) state_nxt = S_HDR;
            S_HDR:   if (accept) state_nxt = hdr_ok ? S_DATA : S_IDLE;
            S_DATA:  if (accept && byte_cnt == 3'd5) state_nxt = top_ok ? S_WRITE : S_IDLE;
            S_WRITE: state_nxt = last_line ? S_DONE : S_DATA;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            n_lines  <= '0;
            wr_ptr   <= '0;
            byte_cnt <= '0;
            asm_q    <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_en) err <= 1'b0;
                end
                S_HDR: begin
                    if (accept) begin
                        if (hdr_ok) begin
                            n_lines  <= in_byte[CW-1:0];
                            wr_ptr   <= '0;
                            byte_cnt <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        asm_q <= {asm_q[LINE_W-9:0], in_byte};
                        if (byte_cnt == 3'd5) begin
                            byte_cnt <= '0;
                            if (!top_ok) err <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end
                S_WRITE: begin
                    mem[wr_ptr[AW-1:0]] <= asm_q;
                    wr_ptr              <= wr_ptr + CW'(1);
                    byte_cnt            <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader against a line-level model
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'd0;
    logic [3:0]  addr = 4'd0;
    logic        in_ready;
    logic [45:0] line;
    logic        core_hold;
    logic        load_done;
    logic        err;

    prog_loader dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .addr      (addr),
        .line      (line),
        .core_hold (core_hold),
        .load_done (load_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [45:0] m_mem [16];
    logic        m_err;
    logic [47:0] ld_lines [16];
    int          done_cnt;
    int          hold_bad;
    int          gap_pct;
    int          cyc_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_cnt++;
        if (load_done) done_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bit ok = 0;
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                load_en = 1'($urandom_range(0, 1));
                if (!core_hold) hold_bad++;
                tick();
            end
            load_en = 1'b0;
        end
        in_valid = 1'b1;
        in_byte  = b;
        while (!ok && guard < 50) begin
            if (!core_hold) hold_bad++;
            if (in_ready) ok = 1;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (!ok) check("byte_timeout", 64'(ok), 64'd1);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            check($sformatf("%s_line%0d", tag, a), 64'(line), 64'(m_mem[a]));
        end
        addr = 4'd0;
    endtask

    task automatic run_load(input string tag, input int hdr, input int gap);
        int  start;
        int  guard;
        bit  bad;
        done_cnt = 0;
        hold_bad = 0;
        gap_pct  = gap;
        bad      = 0;
        load_en  = 1'b1;
        tick();
        load_en  = 1'b0;
        m_err    = 1'b0;
        start    = cyc_cnt;
        check({tag, "_err_clr"}, 64'(err), 64'd0);
        check({tag, "_hold_start"}, 64'(core_hold), 64'd1);
        send_byte(8'(hdr));
        if (hdr == 0 || hdr > 16) begin
            m_err = 1'b1;
            check({tag, "_hdr_idle"}, 64'(core_hold), 64'd0);
        end else begin
            for (int i = 0; i < hdr && !bad; i++) begin
                for (int k = 0; k < 6; k++) send_byte(ld_lines[i][47 - 8*k -: 8]);
                if (ld_lines[i][47:46] != 2'b00) begin
                    bad   = 1;
                    m_err = 1'b1;
                end else begin
                    m_mem[i] = ld_lines[i][45:0];
                end
            end
            if (bad) begin
                check({tag, "_line_err_idle"}, 64'(core_hold), 64'd0);
            end else begin
                guard = 0;
                while (core_hold && guard < 20) begin
                    tick();
                    guard++;
                end
                check({tag, "_idle"}, 64'(core_hold), 64'd0);
                if (gap == 0) check({tag, "_latency"}, 64'(cyc_cnt - start), 64'(7 * hdr + 2));
            end
        end
        check({tag, "_done_pulses"}, 64'(done_cnt), (hdr >= 1 && hdr <= 16 && !bad) ? 64'd1 : 64'd0);
        check({tag, "_hold_gaps"}, 64'(hold_bad), 64'd0);
        check({tag, "_err"}, 64'(err), 64'(m_err));
        sweep(tag);
    endtask

    function automatic logic [47:0] rand_line(input int bad_pct);
        logic [47:0] v;
        v = {$urandom, $urandom};
        v[47:46] = ($urandom_range(0, 99) < bad_pct) ? 2'($urandom_range(1, 3)) : 2'b00;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_err = 1'b0;
        gap_pct = 0;

        rst = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_hold", 64'(core_hold), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b1;
        tick();
        sweep("rst");

        ld_lines[0] = 48'h0000_0000_002A;
        run_load("n1", 1, 0);

        for (int i = 0; i < 16; i++) ld_lines[i] = 48'h0100_0000_0000 + 48'(i);
        run_load("n16", 16, 0);

        for (int i = 0; i < 2; i++) ld_lines[i] = rand_line(0);
        run_load("n2", 2, 0);

        run_load("hdr00", 0, 0);
        run_load("hdr11", 17, 0);

        ld_lines[0] = rand_line(0);
        ld_lines[1] = {8'hC0, 40'($urandom)};
        run_load("c0", 2, 0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(0, 17);
            for (int i = 0; i < 16; i++) ld_lines[i] = rand_line(8);
            run_load($sformatf("rnd%0d", r), n, 40);
        end

        for (int i = 0; i < 3; i++) ld_lines[i] = rand_line(0);
        done_cnt = 0;
        gap_pct  = 30;
        load_en  = 1'b1;
        tick();
        load_en  = 1'b0;
        send_byte(8'd3);
        for (int k = 0; k < 6; k++) send_byte(ld_lines[0][47 - 8*k -: 8]);
        send_byte(ld_lines[1][47:40]);
        send_byte(ld_lines[1][39:32]);
        check("mid_hold", 64'(core_hold), 64'd1);
        rst = 1'b0;
        tick();
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_hold", 64'(core_hold), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        rst = 1'b1;
        tick();
        tick();
        check("mid_rst_done", 64'(done_cnt), 64'd0);
        check("mid_rst_idle", 64'(core_hold), 64'd0);
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        sweep("mid_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
